acq_ctrl: RTL and testbench
===========================

Name: acq_ctrl

Overview:
- Acquisition sequencer between the USB instruction decoder and the TDC channel front-ends.
- On a rising edge of the decoder's `capture` register it opens a measurement window on the enabled channels and counts hit events.
- The window closes on an event limit (`max_count`), a time limit (`max_time`) or host abort. It then flushes, reports the result and stop cause, and returns to idle.

Parameters:
- DATA_WIDTH, 32, width of limit/result words
- CHANNEL, 8, number of TDC channels
- FLUSH_CYCLES, 4, cycles gate stays closed before DONE so in-flight hits settle (>=1)

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- capture  in  1  start/hold level from instruction decoder
- channel_on  in  CHANNEL  per-channel enable, bit i = channel i
- max_count  in  DATA_WIDTH  event limit, 0 = unlimited
- max_time  in  DATA_WIDTH  window length in sys_clk cycles, 0 = unlimited
- hit  in  CHANNEL  single-cycle hit pulses from channels
- gate_en  out  CHANNEL  per-channel acquisition gate
- busy  out  1  high in ARM/RUN/FLUSH
- done  out  1  one-cycle completion pulse
- stop_cause  out  2  00 no channel, 01 count, 10 time, 11 abort
- event_count  out  DATA_WIDTH  hits counted in last/current window
- elapsed  out  DATA_WIDTH  RUN cycles in last/current window

Behaviour:
- Reset: all outputs 0, FSM IDLE, capture edge register 0. Reset takes effect immediately at any state, including mid-RUN; gate_en drops asynchronously.
- Start edge: capture_d registered each cycle; start = capture & ~capture_d. It is honoured only in IDLE. Edges in other states are ignored, so a new edge is required after DONE.
- States and transitions:
  - IDLE: wait for start.
  - ARM (1 cycle):
    - latch channel_on into mask, max_count into cnt_lim, max_time into time_lim
    - clear event_count, elapsed and stop_cause
    - if mask == 0: stop_cause = 00, go to DONE
    - otherwise go to RUN
  - RUN:
    - gate_en = mask; all other states gate_en = 0
    - each cycle: elapsed += 1; event_count += popcount(hit & mask), saturating at all-ones
    - stop conditions, evaluated on next values, priority count > time > abort:
      - count: cnt_lim != 0 and event_count_next >= cnt_lim (popcount can overshoot; final count is reported unclipped)
      - time: time_lim != 0 and elapsed_next == time_lim (RUN lasts exactly time_lim cycles)
      - abort: capture == 0
    - on stop: latch stop_cause, go to FLUSH
    - hits in the stopping cycle are counted
  - FLUSH: down-counter FLUSH_CYCLES; hits ignored; then DONE.
  - DONE (1 cycle): done = 1, then IDLE.
- busy = 1 in ARM, RUN, FLUSH; 0 in IDLE, DONE.
- Latency from capture sampled high (cycle N, with capture_d = 0):
  - ARM at N+1
  - RUN and gate_en at N+2
  - done at (last RUN cycle)+FLUSH_CYCLES+1
- Inputs channel_on, max_count and max_time changing during a window have no effect until the next ARM.
- Results (event_count, elapsed, stop_cause) hold after DONE until the next ARM.
- capture held high through DONE does not retrigger.
- Both limits 0: window runs until capture deasserts (cause 11).

Test Plan:
- channel_on=0x01, max_count=5, max_time=0, one hit on ch0 every 3 cycles, capture 0→1 → gate_en=0x01 two cycles after edge sample; stop after 5th hit; event_count=5, stop_cause=01; done one cycle after FLUSH_CYCLES=4 flush; busy low at done.
- channel_on=0xFF, max_count=0, max_time=100, no hits → RUN exactly 100 cycles; elapsed=100, event_count=0, stop_cause=10.
- channel_on=0x0F, hit=0xFF every cycle, max_count=10, max_time=3 → 4 counted per cycle (mask applied); stop on cycle 3 with count 12 ≥ 10; stop_cause=01 (count wins simultaneous time); event_count=12.
- channel_on=0x03, limits 0, capture dropped after 20 RUN cycles → stop_cause=11, elapsed=20. A second capture edge during FLUSH is ignored; a fresh edge after DONE starts a new window with counters cleared.
- channel_on=0x00, capture edge → ARM then DONE directly; stop_cause=00; gate_en never asserted; busy high for one cycle.
- sys_rst_n asserted mid-RUN with event_count=7 → gate_en, busy, done, event_count, elapsed, stop_cause all 0 immediately. After release with capture still high, no window starts until capture goes low then high.

Source files
------------

// File: rtl/acq_ctrl.sv
// Acquisition sequencer: a capture rising edge opens a gated hit-counting window on the enabled TDC channels.
// Latency: ARM one cycle after the capture edge cycle, gate open the cycle after; done FLUSH_CYCLES+1 after the last RUN cycle.
// Backpressure: none; hits are single-cycle pulses, counted when gated in RUN and dropped in every other state.
module acq_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int CHANNEL      = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  capture,
    input  logic [CHANNEL-1:0]    channel_on,
    input  logic [DATA_WIDTH-1:0] max_count,
    input  logic [DATA_WIDTH-1:0] max_time,
    input  logic [CHANNEL-1:0]    hit,
    output logic [CHANNEL-1:0]    gate_en,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            stop_cause,
    output logic [DATA_WIDTH-1:0] event_count,
    output logic [DATA_WIDTH-1:0] elapsed
);

    localparam int PCW = $clog2(CHANNEL + 1);
    localparam int SW  = DATA_WIDTH + 1;
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic                    capture_q;
    logic                    cap_low_q;
    logic [CHANNEL-1:0]      mask_q;
    logic [DATA_WIDTH-1:0]   cnt_lim_q;
    logic [DATA_WIDTH-1:0]   time_lim_q;
    logic [FCW-1:0]          flush_q;
    logic [CHANNEL-1:0]      gate_en_q;
    logic                    busy_q;
    logic                    done_q;
    logic [1:0]              stop_cause_q;
    logic [DATA_WIDTH-1:0]   event_count_q;
    logic [DATA_WIDTH-1:0]   elapsed_q;

    logic                    start;
    logic [PCW-1:0]          hit_cnt;
    logic [SW-1:0]           count_sum;
    logic [DATA_WIDTH-1:0]   event_count_d;
    logic [DATA_WIDTH-1:0]   elapsed_d;
    logic                    stop_cnt;
    logic                    stop_time;
    logic                    stop_abort;

    // A start needs capture to have been seen low since reset, so a level
    // still high when reset releases cannot open a window by itself.
    assign start = capture & ~capture_q & cap_low_q;

    // Next-value counters and stop conditions for the current RUN cycle.
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < CHANNEL; i++) begin
            hit_cnt = hit_cnt + PCW'(hit[i] & mask_q[i]);
        end
        count_sum     = {1'b0, event_count_q} + SW'(hit_cnt);
        event_count_d = count_sum[DATA_WIDTH] ? '1 : count_sum[DATA_WIDTH-1:0];
        elapsed_d     = elapsed_q + DATA_WIDTH'(1);
        stop_cnt      = (cnt_lim_q != '0) && (event_count_d >= cnt_lim_q);
        stop_time     = (time_lim_q != '0) && (elapsed_d == time_lim_q);
        stop_abort    = ~capture;
    end

    // Sequencer FSM with registered outputs; reset clears everything, gate included.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            capture_q     <= 1'b0;
            cap_low_q     <= 1'b0;
            mask_q        <= '0;
            cnt_lim_q     <= '0;
            time_lim_q    <= '0;
            flush_q       <= '0;
            gate_en_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            stop_cause_q  <= 2'b00;
            event_count_q <= '0;
            elapsed_q     <= '0;
        end else begin
            capture_q <= capture;
            if (!capture) begin
                cap_low_q <= 1'b1;
            end
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ARM;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARM: begin
                    mask_q        <= channel_on;
                    cnt_lim_q     <= max_count;
                    time_lim_q    <= max_time;
                    event_count_q <= '0;
                    elapsed_q     <= '0;
                    stop_cause_q  <= 2'b00;
                    if (channel_on == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= S_RUN;
                        gate_en_q <= channel_on;
                    end
                end
                S_RUN: begin
                    event_count_q <= event_count_d;
                    elapsed_q     <= elapsed_d;
                    if (stop_cnt || stop_time || stop_abort) begin
                        if (stop_cnt) begin
                            stop_cause_q <= 2'b01;
                        end else if (stop_time) begin
                            stop_cause_q <= 2'b10;
                        end else begin
                            stop_cause_q <= 2'b11;
                        end
                        state_q   <= S_FLUSH;
                        gate_en_q <= '0;
                        flush_q   <= FCW'(FLUSH_CYCLES - 1);
                    end
                end
                S_FLUSH: begin
                    if (flush_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        flush_q <= flush_q - FCW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gate_en     = gate_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign stop_cause  = stop_cause_q;
    assign event_count = event_count_q;
    assign elapsed     = elapsed_q;

endmodule

// File: tb/tb_acq_ctrl.sv
// Bench for acq_ctrl: directed and random acquisition windows against a window-level reference model.
// Latency: checks ARM, gate, flush length and done timing cycle by cycle.
// Backpressure: none; hit pulses are driven freely, including during flush.
module tb_acq_ctrl;

    localparam int DW   = 32;
    localparam int CH   = 8;
    localparam int FL   = 4;
    localparam int MAXC = 200;

    logic          sys_clk;
    logic          sys_rst_n;
    logic          capture;
    logic [CH-1:0] channel_on;
    logic [DW-1:0] max_count;
    logic [DW-1:0] max_time;
    logic [CH-1:0] hit;
    logic [CH-1:0] gate_en;
    logic          busy;
    logic          done;
    logic [1:0]    stop_cause;
    logic [DW-1:0] event_count;
    logic [DW-1:0] elapsed;

    int n_checks = 0;
    int n_errors = 0;

    acq_ctrl #(
        .DATA_WIDTH  (DW),
        .CHANNEL     (CH),
        .FLUSH_CYCLES(FL)
    ) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .capture    (capture),
        .channel_on (channel_on),
        .max_count  (max_count),
        .max_time   (max_time),
        .hit        (hit),
        .gate_en    (gate_en),
        .busy       (busy),
        .done       (done),
        .stop_cause (stop_cause),
        .event_count(event_count),
        .elapsed    (elapsed)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // mode: 0 random hits, 1 all hits every cycle, 2 ch0 every 3rd cycle, 3 no hits.
    // abort_at: RUN cycle in which capture is low (0 = never, bounded by MAXC).
    task automatic run_window(input string name, input logic [CH-1:0] ch, input logic [DW-1:0] mc,
                              input logic [DW-1:0] mt, input int abort_at, input int mode);
        logic [CH-1:0] hseq [0:MAXC];
        int            ab;
        int            cum;
        int            stop_k;
        int            cause;
        int            exp_cnt;

        // Reference: walk the window cycle by cycle in plain arithmetic.
        ab      = (abort_at == 0) ? MAXC : abort_at;
        cum     = 0;
        stop_k  = 0;
        cause   = 0;
        exp_cnt = 0;
        for (int k = 0; k <= MAXC; k++) hseq[k] = '0;
        if (ch != '0) begin
            for (int k = 1; k <= MAXC && stop_k == 0; k++) begin
                case (mode)
                    1:       hseq[k] = '1;
                    2:       hseq[k] = (k % 3 == 0) ? CH'(1) : '0;
                    3:       hseq[k] = '0;
                    default: hseq[k] = ($urandom_range(0, 2) == 0) ? CH'($urandom) : '0;
                endcase
                cum = cum + $countones(hseq[k] & ch);
                if (mc != 0 && cum >= int'(mc))      cause = 1;
                else if (mt != 0 && k == int'(mt))   cause = 2;
                else if (k == ab)                    cause = 3;
                if (cause != 0) begin
                    stop_k  = k;
                    exp_cnt = cum;
                end
            end
        end

        capture = 1'b0;
        hit     = '0;
        tick();
        channel_on = ch;
        max_count  = mc;
        max_time   = mt;
        capture    = 1'b1;
        tick();
        @(negedge sys_clk);
        check($sformatf("%s arm busy", name), busy, 1);
        check($sformatf("%s arm gate", name), gate_en, 0);
        tick();
        // Inputs changing after ARM must not affect the window.
        channel_on = CH'($urandom);
        max_count  = $urandom_range(1, 3);
        max_time   = $urandom_range(1, 3);

        if (ch == '0) begin
            @(negedge sys_clk);
            check($sformatf("%s nochan done", name), done, 1);
            check($sformatf("%s nochan busy", name), busy, 0);
            check($sformatf("%s nochan gate", name), gate_en, 0);
            check($sformatf("%s nochan cause", name), stop_cause, 0);
            check($sformatf("%s nochan count", name), event_count, 0);
            tick();
            @(negedge sys_clk);
            check($sformatf("%s nochan post done", name), done, 0);
            check($sformatf("%s nochan post busy", name), busy, 0);
            return;
        end

        for (int k = 1; k <= stop_k; k++) begin
            hit     = hseq[k];
            capture = (k == ab) ? 1'b0 : 1'b1;
            @(negedge sys_clk);
            if (k == 1) begin
                check($sformatf("%s run gate first", name), gate_en, 32'(ch));
                check($sformatf("%s run elapsed cleared", name), elapsed, 0);
                check($sformatf("%s run count cleared", name), event_count, 0);
            end
            if (k == stop_k) begin
                check($sformatf("%s run gate last", name), gate_en, 32'(ch));
                check($sformatf("%s run busy last", name), busy, 1);
            end
            tick();
        end

        for (int f = 1; f <= FL; f++) begin
            hit = '1;
            if (cause == 3 && f == 2) capture = 1'b1;
            @(negedge sys_clk);
            check($sformatf("%s flush%0d gate", name, f), gate_en, 0);
            check($sformatf("%s flush%0d done", name, f), done, 0);
            if (f == FL) check($sformatf("%s flush busy", name), busy, 1);
            tick();
        end

        hit = '0;
        @(negedge sys_clk);
        check($sformatf("%s done pulse", name), done, 1);
        check($sformatf("%s done busy", name), busy, 0);
        check($sformatf("%s cause", name), stop_cause, 32'(cause));
        check($sformatf("%s count", name), event_count, 32'(exp_cnt));
        check($sformatf("%s elapsed", name), elapsed, 32'(stop_k));
        tick();
        @(negedge sys_clk);
        check($sformatf("%s post done", name), done, 0);
        tick();
        @(negedge sys_clk);
        check($sformatf("%s no retrigger", name), busy, 0);
        check($sformatf("%s count held", name), event_count, 32'(exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sys_rst_n  = 1'b0;
        capture    = 1'b0;
        channel_on = '0;
        max_count  = '0;
        max_time   = '0;
        hit        = '0;
        #13;
        check("reset gate", gate_en, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset cause", stop_cause, 0);
        #10;
        sys_rst_n = 1'b1;
        tick();

        run_window("cnt5", 8'h01, 5, 0, 0, 2);
        run_window("time100", 8'hFF, 0, 100, 0, 3);
        run_window("cnt_vs_time", 8'h0F, 10, 3, 0, 1);
        run_window("abort20", 8'h03, 0, 0, 20, 0);
        run_window("abort_again", 8'h03, 0, 0, 9, 0);
        run_window("nochan", 8'h00, 7, 7, 0, 0);

        // Reset mid-RUN with a partially filled counter.
        capture    = 1'b0;
        tick();
        channel_on = 8'h01;
        max_count  = 0;
        max_time   = 0;
        capture    = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 7; k++) begin
            hit = 8'h01;
            tick();
        end
        hit = '0;
        @(negedge sys_clk);
        check("pre_rst count", event_count, 7);
        check("pre_rst gate", gate_en, 32'h01);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("rst gate", gate_en, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst count", event_count, 0);
        check("rst elapsed", elapsed, 0);
        check("rst cause", stop_cause, 0);
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        @(negedge sys_clk);
        check("post_rst no start busy", busy, 0);
        check("post_rst no start gate", gate_en, 0);
        run_window("post_rst", 8'h81, 3, 0, 0, 1);

        for (int i = 0; i < 8; i++) begin
            logic [CH-1:0] rch;
            rch = (i == 5) ? '0 : CH'($urandom);
            run_window($sformatf("rand%0d", i), rch, $urandom_range(0, 25),
                       $urandom_range(0, 40), $urandom_range(1, 60), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
